// File: rtl/reg_loader_pkg.sv
// Shared types for the register-bank preload master: loader states and
// the bank address / data widths of the single-cycle core.
package reg_loader_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_RUN,
    ST_ERR
  } loader_state_e;

endpackage

// File: rtl/loader_xor_accum.sv
// Running 32-bit XOR of the words streamed into the bank, used to verify the
// trailing checksum word when REG_LOADER_CHECKSUM_EN is defined.
module loader_xor_accum
  import reg_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] acc_o
);

  logic [WORD_W-1:0] acc_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q ^ data_i;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/reg_bank_loader.sv
// Preloads the core's register bank from a valid/ready word stream, then hands
// the bank write port to the datapath via sel. Optional checksum: REG_LOADER_CHECKSUM_EN.
module reg_bank_loader
  import reg_loader_pkg::*;
#(
  parameter int START_ADDR = 1,
  parameter int NWORDS     = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WORD_W-1:0]     escribir,
  output logic [REG_ADDR_W-1:0] dirIniciar,
  output logic                  EWIniciar,
  output logic                  sel,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [REG_ADDR_W-1:0] FIRST_ADDR = REG_ADDR_W'(START_ADDR);
  localparam logic [REG_ADDR_W-1:0] LAST_CNT   = REG_ADDR_W'(NWORDS - 1);

  loader_state_e         state_q, state_d;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [REG_ADDR_W-1:0] cnt_q;
  logic [WORD_W-1:0]     escribir_q;
  logic [REG_ADDR_W-1:0] dir_q;
  logic                  ew_q;
  logic                  sel_q;
  logic                  in_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  accept;
  logic                  restart;

  assign accept  = in_valid && in_ready_q;
  assign restart = start && (state_q == ST_IDLE || state_q == ST_RUN || state_q == ST_ERR);

`ifdef REG_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] xor_acc;
  logic              err_q;

  loader_xor_accum u_xor_accum (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (restart),
    .en_i   (state_q == ST_LOAD && accept),
    .data_i (in_data),
    .acc_o  (xor_acc)
  );

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RUN, ST_ERR: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (accept && cnt_q == LAST_CNT) begin
`ifdef REG_LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_RUN;
`endif
        end
      end
`ifdef REG_LOADER_CHECKSUM_EN
      ST_CHECK: if (accept) state_d = (in_data == xor_acc) ? ST_RUN : ST_ERR;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      escribir_q <= '0;
      dir_q      <= '0;
      ew_q       <= 1'b0;
      sel_q      <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef REG_LOADER_CHECKSUM_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == ST_LOAD || state_d == ST_CHECK);
      busy_q     <= (state_d == ST_LOAD || state_d == ST_CHECK);
      // sel/done lag RUN entry by a cycle so the final write pulse lands first
      sel_q      <= (state_q == ST_RUN && state_d == ST_RUN);
      done_q     <= (state_q == ST_RUN && state_d == ST_RUN);
`ifdef REG_LOADER_CHECKSUM_EN
      err_q      <= (state_d == ST_ERR);
`endif
      ew_q       <= 1'b0;
      if (restart) begin
        addr_q <= FIRST_ADDR;
        cnt_q  <= '0;
      end else if (state_q == ST_LOAD && accept) begin
        ew_q       <= 1'b1;
        escribir_q <= in_data;
        dir_q      <= addr_q;
        addr_q     <= addr_q + 1'b1;
        cnt_q      <= cnt_q + 1'b1;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign escribir   = escribir_q;
  assign dirIniciar = dir_q;
  assign EWIniciar  = ew_q;
  assign sel        = sel_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_reg_bank_loader.sv
// Randomized bench for reg_bank_loader: an address/data expectation queue built
// from the stream order is compared against every bank write pulse.
module tb_reg_bank_loader;

  localparam int SA = 1;
  localparam int NW = 31;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] escribir;
  logic [4:0]  dirIniciar;
  logic        EWIniciar;
  logic        sel;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] words [NW];
  logic [31:0] exp_d [$];
  logic [4:0]  exp_a [$];
  logic [31:0] last_d;
  logic [4:0]  last_a;
  bit          have_last = 1'b0;

  reg_bank_loader #(.START_ADDR(SA), .NWORDS(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .escribir   (escribir),
    .dirIniciar (dirIniciar),
    .EWIniciar  (EWIniciar),
    .sel        (sel),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      have_last <= 1'b0;
      exp_d.delete();
      exp_a.delete();
    end
  end

  // Every write pulse must match the oldest accepted word; between pulses the bus holds.
  always @(negedge clk) begin
    if (!rst) begin
      if (EWIniciar) begin
        if (exp_d.size() == 0) begin
          check_val("ew_extra", 32'd1, 32'd0);
        end else begin
          last_d = exp_d.pop_front();
          last_a = exp_a.pop_front();
          check_val("wr_addr", 32'(dirIniciar), 32'(last_a));
          check_val("wr_data", escribir, last_d);
          have_last = 1'b1;
        end
      end else if (have_last) begin
        check_val("hold_data", escribir, last_d);
        check_val("hold_addr", 32'(dirIniciar), 32'(last_a));
      end
      check_val("sel_ew_excl", 32'(sel & EWIniciar), 32'd0);
    end
  end

  task automatic check_all_zero(input string tag);
    check_val({tag, "_escribir"}, escribir, 32'd0);
    check_val({tag, "_dir"}, 32'(dirIniciar), 32'd0);
    check_val({tag, "_ew"}, 32'(EWIniciar), 32'd0);
    check_val({tag, "_sel"}, 32'(sel), 32'd0);
    check_val({tag, "_ready"}, 32'(in_ready), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // mode: 0 = valid held, 1 = valid every other cycle, 2 = random gaps
  task automatic run_load(input int mode, input int start_at, input int abort_at,
                          input bit corrupt);
    int idx = 0;
    int cyc = 0;
    bit toggle = 1'b0;
    bit gap;
    logic [31:0] csum = '0;
    for (int i = 0; i < NW; i++) csum ^= words[i];
    if (corrupt) csum ^= 32'hDEADBEEF;

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_val("start_sel_low", 32'(sel), 32'd0);
    check_val("start_busy", 32'(busy), 32'd1);
    check_val("start_err_clr", 32'(err), 32'd0);

    while (idx < NW && cyc < 2000) begin
      if (idx == abort_at) begin
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("abort");
        return;
      end
      gap = (mode == 1) ? toggle : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      toggle = ~toggle;
      start = (idx == start_at);
      in_valid = ~gap;
      in_data = gap ? $urandom : words[idx];
      if (in_valid && in_ready) begin
        exp_d.push_back(words[idx]);
        exp_a.push_back(5'(SA + idx));
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (idx < NW) begin
      check_val("load_timeout", 32'(idx), 32'(NW));
      return;
    end

`ifdef REG_LOADER_CHECKSUM_EN
    check_val("chk_ready", 32'(in_ready), 32'd1);
    check_val("chk_sel", 32'(sel), 32'd0);
    in_valid = 1'b1;
    in_data = csum;
    @(negedge clk);
    in_valid = 1'b0;
    check_val("post_chk_ready", 32'(in_ready), 32'd0);
    check_val("post_chk_err", 32'(err), 32'(corrupt));
    check_val("post_chk_sel", 32'(sel), 32'd0);
    @(negedge clk);
    check_val("end_sel", 32'(sel), 32'(!corrupt));
    check_val("end_done", 32'(done), 32'(!corrupt));
    check_val("end_err", 32'(err), 32'(corrupt));
    check_val("end_busy", 32'(busy), 32'd0);
`else
    check_val("last_ready_drop", 32'(in_ready), 32'd0);
    check_val("last_sel_low", 32'(sel), 32'd0);
    @(negedge clk);
    check_val("end_sel", 32'(sel), 32'd1);
    check_val("end_done", 32'(done), 32'd1);
    check_val("end_busy", 32'(busy), 32'd0);
    check_val("end_err", 32'(err), 32'd0);
    check_val("end_ready", 32'(in_ready), 32'd0);
`endif
    check_val("queue_drained", 32'(exp_d.size()), 32'd0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NW; i++) words[i] = $urandom;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // valid held, words k * 0x11111111
    for (int i = 0; i < NW; i++) words[i] = 32'(i + 1) * 32'h1111_1111;
    run_load(0, -1, -1, 1'b0);

    // restart from RUN with backpressure every other cycle
    fill_random();
    run_load(1, -1, -1, 1'b0);

    // random gaps, a stray start mid-load
    fill_random();
    run_load(2, 5, -1, 1'b0);

`ifdef REG_LOADER_CHECKSUM_EN
    for (int i = 0; i < NW; i++) words[i] = 32'(i + 1);
    run_load(0, -1, -1, 1'b0);
    run_load(0, -1, -1, 1'b1);
    fill_random();
    run_load(2, -1, -1, 1'b0);
`endif

    // reset after 10 words, then a fresh load from the first address
    fill_random();
    run_load(0, -1, 10, 1'b0);
    fill_random();
    run_load(2, -1, -1, 1'b0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_bank_loader.md
# reg_bank_loader

Initialization master for the single-cycle MIPS core's register-bank preload port. It accepts a stream of 32-bit words over a valid/ready handshake and writes them into consecutive register addresses through the core's `escribir`/`dirIniciar`/`EWIniciar` inputs. When loading completes, it raises `sel` so the bank write port is handed to the datapath and the program runs. It sits beside the core top level and drives those four signals directly.

## Interface
- `START_ADDR`, 1: first register address written. Address 0 is skipped by default.
- `NWORDS`, 31: number of data words per load. `START_ADDR+NWORDS-1` must be ≤ 31.
- `clk` in 1: core clock. All state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a load. Honoured in IDLE, RUN and ERR; ignored otherwise.
- `in_data` in 32: stream word.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader accepts a word this cycle.
- `escribir` out 32: bank write data.
- `dirIniciar` out 5: bank write address.
- `EWIniciar` out 1: bank write enable, one-cycle pulse per word.
- `sel` out 1: 0 = loader owns the bank write port; 1 = datapath owns it.
- `busy` out 1: high in LOAD and CHECK.
- `done` out 1: high in RUN.
- `err` out 1: checksum failure. Constant 0 without the macro.

## Operation
- **States:** IDLE, LOAD, CHECK (macro only), RUN, ERR.
- **IDLE:**
  - `sel`=0, `in_ready`=0.
  - `start` → LOAD; address counter ← `START_ADDR`, word count ← 0, checksum ← 0.
- **LOAD:**
  - `in_ready`=1.
  - Accept when `in_valid && in_ready`. The next cycle registers `escribir`=word, `dirIniciar`=counter, `EWIniciar`=1.
  - Counter increments by 1 per accepted word, 5-bit, with no wrap-around (guaranteed by the parameter rule).
  - When no word is accepted, `EWIniciar`=0 the next cycle. `escribir`/`dirIniciar` hold their last values.
  - Accepting word `NWORDS-1` → CHECK (macro) or RUN (no macro). `in_ready` drops in the following cycle.
- **CHECK:**
  - `in_ready`=1. Accepts exactly one word and never writes it to the bank.
  - Word equal to the XOR of all `NWORDS` data words → RUN; otherwise → ERR.
- **RUN:**
  - `sel`=1, `done`=1, `EWIniciar`=0, `in_ready`=0.
  - `start` → LOAD: `sel`=0 from the next cycle.
- **ERR:**
  - `sel`=0, `err`=1, `in_ready`=0.
  - `start` → LOAD and clears `err`.
- **Write pulse vs. state change:** the final write pulse is issued in the cycle after the last accept, even though the state has already advanced. In no-macro mode, `sel` rises in the cycle after that pulse, so `sel` and `EWIniciar` are never high together.
- **Reset value of every output:** 0 (`escribir`, `dirIniciar`, `EWIniciar`, `sel`, `in_ready`, `busy`, `done`, `err`). State ← IDLE.
- **Reset mid-load:** abandons the load. `sel` stays 0, counters are cleared, any pending write pulse is dropped.
- **Ignored inputs:** `in_valid` outside LOAD/CHECK is ignored. `start` during LOAD/CHECK is ignored.

## Timing
- Throughput: one word per cycle while `in_valid` is held high.
- Latency: accept edge → `EWIniciar` high one cycle later (registered outputs).
- Load time: `NWORDS` accept cycles (+1 with the macro), then `sel`=1 two cycles after the final accept. The `sel` delay comes from the final write pulse plus the state update.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- `REG_LOADER_CHECKSUM_EN`:
  - Defined: CHECK and ERR states exist, a 32-bit XOR accumulator is built, and `err` is live.
  - Undefined: LOAD goes straight to RUN, and `err` is tied to 0.

## Structure
- Shared package `reg_loader_pkg`:
  - state enum
  - `REG_ADDR_W`=5
  - `WORD_W`=32
- One natural sub-module, `loader_xor_accum`: clear, enable, data in, 32-bit running XOR out. Instantiated only under the macro.

## Test plan
- **Basic load:** reset, `start`, stream words 0x11111111 × k for addresses 1..31 with `in_valid` held → 31 `EWIniciar` pulses, `dirIniciar` 1..31 in order, `sel`=1 and `done`=1 two cycles after the last accept.
- **Backpressure gaps:** drop `in_valid` every other cycle → no extra pulses, addresses still contiguous, `escribir` holds between pulses.
- **Checksum pass/fail (macro):**
  - Words 1..31, then checksum = XOR(1..31) = 0 → RUN.
  - Same stream with checksum 0xDEADBEEF → ERR, `err`=1, `sel`=0.
- **Restart from RUN:** `start` while `done`=1 → `sel`=0 next cycle, next write goes to address `START_ADDR`.
- **Reset mid-load:** assert `rst` after 10 words → all outputs 0 next cycle. A new `start` writes from address 1.
- **Ignored start:** pulse `start` during LOAD → no effect on address sequence or state.
